// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag types and helpers
// for the pipelined execute-stage ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NAND = 4'd2,
      OP_XOR  = 4'd3,
      OP_INC  = 4'd4,
      OP_SRA  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SLL  = 4'd7,
      OP_LW   = 4'd8,
      OP_SW   = 4'd9,
      OP_LHB  = 4'd10,
      OP_LLB  = 4'd11,
      OP_R12  = 4'd12,
      OP_R13  = 4'd13,
      OP_R14  = 4'd14,
      OP_R15  = 4'd15
   } op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
   } flags_t;

   function automatic logic op_sets_flags(op_t op);
      return (op <= OP_INC);
   endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath mapping
// (op, a, b) to result, flags and flag-update enable.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output flags_t           flags,
   output logic             fupd
);

   localparam int H = WIDTH / 2;
   localparam int M = WIDTH - 1;

   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;
   logic             ovf_add;
   logic             ovf_sub;

   assign sh  = b[SHW-1:0];
   assign sum = a + b;
   assign dif = a - b;

   assign ovf_add = (a[M] == b[M]) && (sum[M] != a[M]);
   assign ovf_sub = (a[M] != b[M]) && (dif[M] != a[M]);

   // Result mux; reserved opcodes yield zero.
   always_comb begin
      result = '0;
      case (op)
         OP_ADD, OP_INC,
         OP_LW, OP_SW: result = sum;
         OP_SUB:       result = dif;
         OP_NAND:      result = ~(a & b);
         OP_XOR:       result = a ^ b;
         OP_SRA:       result = WIDTH'($signed(a) >>> sh);
         OP_SRL:       result = a >> sh;
         OP_SLL:       result = a << sh;
         OP_LHB:       result = {b[H-1:0], a[H-1:0]};
         OP_LLB:       result = {{(WIDTH-H){b[H-1]}}, b[H-1:0]};
         default:      result = '0;
      endcase
   end

   // Flags; overflow only meaningful for add/sub class.
   always_comb begin
      flags.n = result[M];
      flags.z = (result == '0);
      flags.v = 1'b0;
      unique case (1'b1)
         (op == OP_ADD),
         (op == OP_INC): flags.v = ovf_add;
         (op == OP_SUB): flags.v = ovf_sub;
         default:        flags.v = 1'b0;
      endcase
   end

   assign fupd = op_sets_flags(op);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready
// handshakes, flush and a committed N/Z/V register.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_v
);

   logic             s1_valid;
   op_t              s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   flags_t           s2_flags;
   logic             s2_fupd;

   logic [WIDTH-1:0] c_result;
   flags_t           c_flags;
   logic             c_fupd;

   flags_t           flags_q;

   logic             s2_load;
   logic             s1_load;
   logic             retire;

   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load && !flush;
   assign retire   = s2_valid && out_ready && !flush;

   alu_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .op     (s1_op),
      .a      (s1_a),
      .b      (s1_b),
      .result (c_result),
      .flags  (c_flags),
      .fupd   (c_fupd)
   );

   // S1 operand latch; flush drops any incoming op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= op_t'(op);
            s1_a  <= a;
            s1_b  <= b;
         end
      end
   end

   // S2 result register; holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_flags  <= '0;
         s2_fupd   <= 1'b0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= c_result;
            s2_flags  <= c_flags;
            s2_fupd   <= c_fupd;
         end
      end
   end

   // Commit flags from the retiring S2 entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (retire && s2_fupd) begin
         flags_q <= s2_flags;
      end
   end

   assign out_valid = s2_valid;
   assign result    = s2_result;
   assign flag_n    = flags_q.n;
   assign flag_z    = flags_q.z;
   assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe
// covering arithmetic, flags, stalls, flush and reset.
module tb_alu_pipe;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [3:0]   op = 4'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] result;
   logic         flag_n;
   logic         flag_z;
   logic         flag_v;

   alu_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_v    (flag_v)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [2:0]   fl;
      logic         fupd;
   } exp_t;

   exp_t         q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [2:0]   exp_fl = 3'b000;
   logic [W-1:0] last_res = '0;
   logic [W-1:0] hold;
   logic         acc;

   task automatic check(string tag, logic [W-1:0] obs,
                        logic [W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(logic [3:0] o,
                                  logic [W-1:0] x,
                                  logic [W-1:0] y);
      exp_t                e;
      logic signed [W-1:0] sx;
      int                  sa;
      int                  sb;
      int                  s;
      logic                v;
      sx = x;
      sa = int'($signed(x));
      sb = int'($signed(y));
      v  = 1'b0;
      case (o)
         4'd0, 4'd4, 4'd8, 4'd9: e.res = x + y;
         4'd1:  e.res = x - y;
         4'd2:  e.res = ~(x & y);
         4'd3:  e.res = x ^ y;
         4'd5:  e.res = sx >>> y[3:0];
         4'd6:  e.res = x >> y[3:0];
         4'd7:  e.res = x << y[3:0];
         4'd10: e.res = {y[7:0], x[7:0]};
         4'd11: e.res = {{8{y[7]}}, y[7:0]};
         default: e.res = '0;
      endcase
      if (o == 4'd0 || o == 4'd4) begin
         s = sa + sb;
         v = (s > 32767) || (s < -32768);
      end else if (o == 4'd1) begin
         s = sa - sb;
         v = (s > 32767) || (s < -32768);
      end
      e.fl   = {e.res[W-1], (e.res == '0), v};
      e.fupd = (o <= 4'd4);
      return e;
   endfunction

   task automatic step(output logic took);
      exp_t e;
      took = 1'b0;
      @(negedge clk);
      check("flags", W'({flag_n, flag_z, flag_v}), W'(exp_fl));
      if (!flush && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            assert (q.size() != 0) else begin
               n_bad++;
               $error("FAIL spurious: got %h want none", result);
            end
         end else begin
            e = q.pop_front();
            check("result", result, e.res);
            last_res = result;
            if (e.fupd) exp_fl = e.fl;
         end
      end
      if (!flush && in_valid && in_ready) begin
         q.push_back(model(op, a, b));
         took = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [3:0] o, logic [W-1:0] x,
                       logic [W-1:0] y);
      logic t;
      t = 1'b0;
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !t; i++) step(t);
      if (!t) begin
         n_cmp++;
         n_bad++;
         $error("FAIL accept_timeout: got none want accept");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      logic t;
      int   i;
      out_ready = 1'b1;
      i = 0;
      while ((q.size() != 0 || out_valid) && i < 50) begin
         step(t);
         i++;
      end
      if (i >= 50) begin
         n_cmp++;
         n_bad++;
         $error("FAIL drain_timeout: got %0d left want 0", q.size());
      end
   endtask

   initial begin
      #2;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_result", result, '0);
      check("rst_flags", W'({flag_n, flag_z, flag_v}), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      send(4'd0, 16'h7FFF, 16'h0001);
      drain();
      check("add_ovf_res", last_res, 16'h8000);
      check("add_ovf_flg", W'({flag_n, flag_z, flag_v}), W'(3'b101));

      send(4'd1, 16'h8000, 16'h0001);
      drain();
      check("sub_ovf_res", last_res, 16'h7FFF);
      check("sub_ovf_flg", W'({flag_n, flag_z, flag_v}), W'(3'b001));
      send(4'd1, 16'h0005, 16'h0005);
      drain();
      check("sub_zero_flg", W'({flag_n, flag_z, flag_v}), W'(3'b010));

      send(4'd0, 16'h0001, 16'h0001);
      send(4'd5, 16'h8000, 16'h0013);
      drain();
      check("sra_res", last_res, 16'hF000);
      check("sra_flg", W'({flag_n, flag_z, flag_v}), W'(3'b000));

      send(4'd1, 16'h0000, 16'h0001);
      send(4'd10, 16'h1234, 16'h00AB);
      drain();
      check("lhb_res", last_res, 16'hAB34);
      send(4'd11, 16'h0000, 16'h0080);
      drain();
      check("llb_res", last_res, 16'hFF80);
      check("lxb_flg", W'({flag_n, flag_z, flag_v}), W'(3'b100));

      out_ready = 1'b0;
      op = 4'd0; a = 16'd1; b = 16'd2;
      in_valid = 1'b1;
      step(acc);
      check("stall_acc1", W'(acc), W'(1));
      op = 4'd1; a = 16'd3; b = 16'd3;
      step(acc);
      check("stall_acc2", W'(acc), W'(1));
      op = 4'd3; a = 16'h0005; b = 16'h0006;
      check("stall_ready", W'(in_ready), W'(0));
      hold = result;
      check("stall_head", hold, 16'h0003);
      for (int i = 0; i < 3; i++) begin
         check("stall_ov", W'(out_valid), W'(1));
         check("stall_hold", result, hold);
         check("stall_rdy", W'(in_ready), W'(0));
         step(acc);
      end
      out_ready = 1'b1;
      send(4'd3, 16'h0005, 16'h0006);
      send(4'd4, 16'h7FFF, 16'h0001);
      drain();
      check("stream_last", last_res, 16'h8000);
      check("stream_flg", W'({flag_n, flag_z, flag_v}), W'(3'b101));

      send(4'd0, 16'h0001, 16'h0001);
      drain();
      send(4'd1, 16'h0000, 16'h0001);
      send(4'd1, 16'h0000, 16'h0002);
      check("pre_flush_ov", W'(out_valid), W'(1));
      flush = 1'b1;
      op = 4'd0; a = 16'd9; b = 16'd9;
      in_valid = 1'b1;
      #1;
      check("flush_ready", W'(in_ready), W'(0));
      step(acc);
      flush = 1'b0;
      in_valid = 1'b0;
      q.delete();
      check("flush_ov", W'(out_valid), W'(0));
      check("flush_flg", W'({flag_n, flag_z, flag_v}), W'(3'b000));
      step(acc);
      check("flush_ov2", W'(out_valid), W'(0));

      send(4'd1, 16'h0000, 16'h0001);
      drain();
      out_ready = 1'b0;
      send(4'd0, 16'h0001, 16'h0002);
      send(4'd0, 16'h0003, 16'h0004);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_ov", W'(out_valid), W'(0));
      check("arst_flg", W'({flag_n, flag_z, flag_v}), W'(0));
      check("arst_res", result, '0);
      q.delete();
      exp_fl = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_ready", W'(in_ready), W'(1));
      send(4'd0, 16'h0002, 16'h0002);
      drain();
      check("post_rst_res", last_res, 16'h0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU with a valid/ready handshake on both sides and an architectural flag register (N, Z, V) that each opcode updates selectively. It sits in the execute stage between the ID/EX operand latch and the EX/MEM register. Compared with the current combinational ALU it adds configurable width, correct signed overflow on ADD/SUB/INC, backpressure, flush, and flag state that persists across instructions.

## Interface
- WIDTH, 16, datapath width in bits; must be even and ≥ 8.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock, asynchronous, active-low.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  op/a/b are valid this cycle.
- in_ready  out  1  the block accepts an operation this cycle.
- op  in  4  opcode.
- a  in  WIDTH  operand 1.
- b  in  WIDTH  operand 2 or shift amount.
- out_valid  out  1  result is valid this cycle.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  WIDTH  result of the head operation.
- flag_n, flag_z, flag_v  out  1 each  committed flag register.

## Operation
- Opcodes:
  - 0 ADD, 4 INC, 8 LW, 9 SW: a+b.
  - 1 SUB: a−b.
  - 2 NAND: ~(a&b).
  - 3 XOR: a^b.
  - 5 SRA: a>>>b[SHW-1:0], arithmetic.
  - 6 SRL: a>>b[SHW-1:0].
  - 7 SLL: a<<b[SHW-1:0].
  - 10 LHB: {b[WIDTH/2-1:0], a[WIDTH/2-1:0]}.
  - 11 LLB: b[WIDTH/2-1:0] sign-extended to WIDTH.
  - 12–15: result 0.
- Shift amounts use only the low SHW bits of b. Upper bits of b are ignored.
- Flag update enable is set for ops 0–4 only. All other ops leave the flag register unchanged.
- N is result[WIDTH-1]. Z is (result==0).
- V for ADD and INC: a and b have the same MSB and the result MSB differs from a's MSB.
- V for SUB: a and b have different MSBs and the result MSB differs from a's MSB.
- V is 0 for NAND and XOR.
- Carry is never reported.
- Stage S1 registers {op, a, b}.
- Stage S2 registers {result, n, z, v, fupd}. It computes these from S1 contents.
- Flag register commit:
  - Writes only on an output handshake (out_valid && out_ready) with fupd=1.
  - Loads S2's n, z, v.
  - Flags therefore reflect the last retired flag-setting op.

## Timing
- Reset values: S1 and S2 valid = 0, out_valid = 0, result = 0, flag_n/z/v = 0, in_ready = 1.
- Latency is 2 cycles. An op accepted at edge k shows out_valid=1 after edge k+1 when there is no stall.
- Throughput is 1 op/cycle while out_ready=1.
- Advance rule:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S2 loads.
  - in_ready = !s1_valid || s2_load. It is combinational, with no dependence on in_valid.
- While out_valid=1 and out_ready=0, result and out_valid hold stable.
- flush has priority over every other input:
  - Clears both valids at the next edge.
  - No flag commit that cycle, even if out_ready=1.
  - in_ready is forced to 0 during flush.
- Simultaneous flush and input handshake: the input op is discarded.
- Reset asserted mid-operation empties the pipe and clears flags immediately, without waiting for a clock.
- A flag commit and a new S2 load in the same cycle: the commit uses the retiring S2 contents.

## Structure
- Package alu_pkg holds:
  - op_t enum for the 16 encodings.
  - flags_t struct {n, z, v}.
  - function op_sets_flags(op_t).
- Sub-module alu_core: purely combinational. Maps (op, a, b) to (result, n, z, v, fupd) and is parametrised by WIDTH.
- alu_pipe holds the pipeline registers, handshake logic, and flag register.

## Test plan
- ADD 16'h7FFF + 16'h0001 → result 16'h8000. After retire: N=1, Z=0, V=1.
- SUB 16'h8000 − 16'h0001 → result 16'h7FFF, N=0, V=1. Then SUB 5−5 → Z=1, V=0.
- ADD 1+1 retires, then SRA 16'h8000 by b=16'h0013 (amount 3) → result 16'hF000. Flags remain N=0, Z=0, V=0 from the ADD.
- LHB a=16'h1234, b=16'h00AB → 16'hAB34. LLB b=16'h0080 → 16'hFF80. Neither changes flags.
- Stream 4 back-to-back ops with out_ready held 0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - No op is lost or duplicated.
  - Results emerge in order.
  - Flags match the last flag-setting op only after its handshake.
- flush with S1 and S2 full and out_ready=1 → out_valid=0 next cycle and the flags are unchanged. Asserting rst_n=0 mid-stream clears out_valid and flags at once, before the next clock edge.
